// File: rtl/ext_link_pkg.sv
// Shared definitions for the external link: controller states, default
// timing constants and a small state classification helper.
package ext_link_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC,
    S_ACK1_LO,
    S_ACK1_HI,
    S_GAP,
    S_START,
    S_DATA,
    S_STOP,
    S_ACK2_LO,
    S_ACK2_HI,
    S_RECOVER
  } link_state_e;

  localparam logic [15:0] DEF_BAUD_CYCLES    = 16'd8;
  localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd1024;
  localparam int          DEF_PACKET_WIDTH   = 10;
  localparam int          DEF_FIFO_DEPTH     = 4;

  // True for the four states that wait on the far-end ack line.
  function automatic logic is_ack_state(input link_state_e s);
    return (s == S_ACK1_LO) || (s == S_ACK1_HI) ||
           (s == S_ACK2_LO) || (s == S_ACK2_HI);
  endfunction

endpackage

// File: rtl/ext_link_fifo.sv
// Packet queue for the link transmitter. DEPTH must be a power of two so the
// pointers wrap naturally. A push while full is dropped even if a pop happens
// on the same edge.
module ext_link_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Payload storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ext_link_tx.sv
// Link transmitter: queues packets, sends a sync pulse, waits for the far
// end's ack pulse, sends a UART-like frame (start, LSB-first data, stop),
// then waits for a second ack. Any ack wait that times out drops the packet.
module ext_link_tx
  import ext_link_pkg::*;
#(
  parameter logic [15:0] BAUD_CYCLES    = DEF_BAUD_CYCLES,
  parameter int          PACKET_WIDTH   = DEF_PACKET_WIDTH,
  parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int          FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_en,
  input  logic [PACKET_WIDTH-1:0] wr_data,
  output logic                    full,
  output logic                    empty,
  output logic                    tx,
  input  logic                    rx,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int            BW       = $clog2(PACKET_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(PACKET_WIDTH - 1);

  link_state_e             state, state_nx;
  logic [15:0]             baud_cnt, baud_cnt_nx;
  logic [15:0]             tmo_cnt, tmo_cnt_nx;
  logic [BW-1:0]           bit_cnt, bit_cnt_nx;
  logic [PACKET_WIDTH-1:0] shreg, shreg_nx;
  logic [PACKET_WIDTH-1:0] head;
  logic                    tx_nx, done_nx, err_nx;
  logic                    fifo_pop;
  logic                    rx_p0, rx_p1;
  logic                    baud_end;

  ext_link_fifo #(
    .DATA_W (PACKET_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (wr_en),
    .pop     (fifo_pop),
    .wr_data (wr_data),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign baud_end = (baud_cnt == BAUD_CYCLES - 16'd1);
  assign busy     = (state != S_IDLE);

  // rx synchronizer stage boundary: two flops, idle-high reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  // Next-state, counter, shifter and registered-output decode.
  always_comb begin
    state_nx    = state;
    baud_cnt_nx = baud_cnt;
    tmo_cnt_nx  = '0;
    bit_cnt_nx  = bit_cnt;
    shreg_nx    = shreg;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    fifo_pop    = 1'b0;
    tx_nx       = 1'b1;

    case (state)
      S_IDLE: begin
        if (!empty) begin
          shreg_nx    = head;
          fifo_pop    = 1'b1;
          baud_cnt_nx = '0;
          bit_cnt_nx  = '0;
          state_nx    = S_SYNC;
        end
      end
      S_SYNC, S_GAP, S_START, S_STOP, S_RECOVER: begin
        if (baud_end) begin
          baud_cnt_nx = '0;
          case (state)
            S_SYNC:  state_nx = S_ACK1_LO;
            S_GAP:   state_nx = S_START;
            S_START: state_nx = S_DATA;
            S_STOP:  state_nx = S_ACK2_LO;
            default: state_nx = S_IDLE;
          endcase
        end else begin
          baud_cnt_nx = baud_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_cnt_nx = '0;
          shreg_nx    = shreg >> 1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nx = '0;
            state_nx   = S_STOP;
          end else begin
            bit_cnt_nx = bit_cnt + BW'(1);
          end
        end else begin
          baud_cnt_nx = baud_cnt + 16'd1;
        end
      end
      S_ACK1_LO: if (!rx_p1) state_nx = S_ACK1_HI;
      S_ACK1_HI: if (rx_p1)  state_nx = S_GAP;
      S_ACK2_LO: if (!rx_p1) state_nx = S_ACK2_HI;
      S_ACK2_HI: begin
        if (rx_p1) begin
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // A wait that has not seen its ack edge counts toward the timeout;
    // leaving the state leaves tmo_cnt_nx at zero for the next wait.
    if (is_ack_state(state) && (state_nx == state)) begin
      if (tmo_cnt == TIMEOUT_CYCLES - 16'd1) begin
        err_nx      = 1'b1;
        baud_cnt_nx = '0;
        state_nx    = S_RECOVER;
      end else begin
        tmo_cnt_nx = tmo_cnt + 16'd1;
      end
    end

    case (state_nx)
      S_SYNC, S_START: tx_nx = 1'b0;
      S_DATA:          tx_nx = shreg_nx[0];
      default:         tx_nx = 1'b1;
    endcase
  end

  // Controller state boundary: state, counters, shifter and line outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      tmo_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_cnt_nx;
      tmo_cnt  <= tmo_cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      shreg    <= shreg_nx;
      tx       <= tx_nx;
      done     <= done_nx;
      err      <= err_nx;
    end
  end

endmodule

// File: tb/tb_ext_link_tx.sv
// Bench for ext_link_tx: a far-end responder acks and decodes frames, a
// waveform-level reference predicts every output each cycle, and directed
// scenarios pin literal values.
module tb_ext_link_tx;

  localparam int B  = 8;
  localparam int T  = 1024;
  localparam int PW = 10;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en;
  logic [PW-1:0] wr_data;
  logic          full, empty, tx, busy, done, err;
  logic          rx;

  int checks = 0;
  int errors = 0;

  ext_link_tx #(
    .BAUD_CYCLES    (16'd8),
    .PACKET_WIDTH   (PW),
    .TIMEOUT_CYCLES (16'd1024),
    .FIFO_DEPTH     (D)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .tx      (tx),
    .rx      (rx),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference: line waveform built from packet contents
  localparam int M_IDLE = 0, M_WAVE = 1, M_ALO = 2, M_AHI = 3;
  logic          m_q[$];
  logic [PW-1:0] m_fifo[$];
  int            m_mode = M_IDLE;
  bit            m_wave_to_ack = 1'b0;
  int            m_ack_no = 1;
  int            m_waited = 0;
  logic          m_r1 = 1'b1, m_r2 = 1'b1, m_rs;
  logic [PW-1:0] m_pkt = '0;
  logic          m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  bit            m_pop, m_push;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_fifo.delete();
      m_q.delete();
      m_mode = M_IDLE;
      m_r1 = 1'b1;
      m_r2 = 1'b1;
      m_tx = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_err = 1'b0;
    end else begin
      // rx as seen by the logic is the line value from two edges earlier
      m_rs = m_r2;
      m_r2 = m_r1;
      m_r1 = rx;
      m_done = 1'b0;
      m_err = 1'b0;
      m_push = wr_en && (m_fifo.size() < D);
      m_pop  = (m_mode == M_IDLE) && (m_fifo.size() > 0);
      if (m_pop) m_pkt = m_fifo.pop_front();
      if (m_push) m_fifo.push_back(wr_data);
      m_tx = 1'b1;
      case (m_mode)
        M_IDLE: begin
          if (m_pop) begin
            repeat (B) m_q.push_back(1'b0);
            m_wave_to_ack = 1'b1;
            m_ack_no = 1;
            m_mode = M_WAVE;
            m_tx = m_q.pop_front();
          end
        end
        M_WAVE: begin
          if (m_q.size() > 0) m_tx = m_q.pop_front();
          else if (m_wave_to_ack) begin
            m_mode = M_ALO;
            m_waited = 0;
          end else m_mode = M_IDLE;
        end
        default: begin
          m_waited++;
          if (m_mode == M_ALO && !m_rs) begin
            m_mode = M_AHI;
            m_waited = 0;
          end else if (m_mode == M_AHI && m_rs) begin
            if (m_ack_no == 1) begin
              repeat (B) m_q.push_back(1'b1);
              repeat (B) m_q.push_back(1'b0);
              for (int i = 0; i < PW; i++) repeat (B) m_q.push_back(m_pkt[i]);
              repeat (B) m_q.push_back(1'b1);
              m_ack_no = 2;
              m_wave_to_ack = 1'b1;
              m_mode = M_WAVE;
              m_tx = m_q.pop_front();
            end else begin
              m_done = 1'b1;
              m_mode = M_IDLE;
            end
          end else if (m_waited == T) begin
            m_err = 1'b1;
            repeat (B) m_q.push_back(1'b1);
            m_wave_to_ack = 1'b0;
            m_mode = M_WAVE;
            m_tx = m_q.pop_front();
          end
        end
      endcase
      m_busy = (m_mode != M_IDLE);
    end
  end

  // Per-cycle comparison of every output against the reference.
  always @(negedge clk) begin
    check("tx",    tx,    m_tx);
    check("busy",  busy,  m_busy);
    check("done",  done,  m_done);
    check("err",   err,   m_err);
    check("empty", empty, m_fifo.size() == 0);
    check("full",  full,  m_fifo.size() == D);
  end

  // ---------------- far-end responder: acks sync and frame, decodes data
  bit            ack_en = 1'b1;
  int            glitch_req = 0, glitch_ack = 0;
  int            cur_bit = -1;
  int            sync_len = 0;
  int            r_n, r_k;
  logic [11:0]   r_frame, last_frame = '0;
  logic [PW-1:0] cap[$];

  initial begin
    rx = 1'b1;
    forever begin
      @(negedge clk);
      if (glitch_req != glitch_ack) begin
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        glitch_ack = glitch_req;
      end else if (rstn && tx === 1'b0) begin
        r_n = 0;
        while (tx === 1'b0 && r_n < 200) begin
          r_n++;
          @(negedge clk);
        end
        sync_len = r_n;
        if (ack_en) begin
          repeat (9) @(negedge clk);
          rx = 1'b0;
          repeat (2) @(negedge clk);
          rx = 1'b1;
          r_k = 0;
          while (tx !== 1'b0 && r_k < 200) begin
            @(negedge clk);
            r_k++;
          end
          if (tx === 1'b0) begin
            repeat (B / 2) @(negedge clk);
            r_frame[0] = tx;
            for (int i = 1; i < 12; i++) begin
              repeat (B) @(negedge clk);
              r_frame[i] = tx;
              cur_bit = i - 1;
            end
            cur_bit = -1;
            last_frame = r_frame;
            cap.push_back(r_frame[10:1]);
            repeat (B / 2 + 9) @(negedge clk);
            rx = 1'b0;
            repeat (2) @(negedge clk);
            rx = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic push_pkt(input logic [PW-1:0] d);
    wr_data = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, done, 1'b1);
  endtask

  logic [PW-1:0] burst[5];
  int            n;
  bit            bad;

  initial begin
    rstn = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_tx",    tx,    1'b1);
    check("rst_busy",  busy,  1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full",  full,  1'b0);
    check("rst_done",  done,  1'b0);
    check("rst_err",   err,   1'b0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single packet 0x2A5: frame start/data/stop pattern 0,1,0,1,0,0,1,0,1,0,1,1
    push_pkt(10'h2A5);
    wait_done("t1_done", 400);
    @(negedge clk);
    check("t1_done_one_cycle", done, 1'b0);
    check("t1_sync_len", sync_len, 8);
    check("t1_frame", last_frame, 12'hD4A);
    check("t1_data", cap[0], 10'h2A5);
    repeat (4) @(negedge clk);

    // Five pushes into an empty FIFO while a frame is in flight
    push_pkt(10'h001);
    n = 0;
    while (!(busy === 1'b1 && empty === 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t2_busy_empty", {busy, empty}, 2'b11);
    burst[0] = 10'h3FF; burst[1] = 10'h155; burst[2] = 10'h2AA;
    burst[3] = 10'h0F0; burst[4] = 10'h123;
    for (int i = 0; i < 5; i++) begin
      wr_data = burst[i];
      wr_en = 1'b1;
      @(negedge clk);
      if (i == 3) check("t2_full_after_4th", full, 1'b1);
      if (i == 4) check("t2_full_after_5th", full, 1'b1);
    end
    wr_en = 1'b0;
    n = 0;
    while (cap.size() < 6 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t2_frame_count", cap.size(), 6);
    check("t2_pkt_a", cap[1], 10'h001);
    check("t2_pkt_b", cap[2], 10'h3FF);
    check("t2_pkt_c", cap[3], 10'h155);
    check("t2_pkt_d", cap[4], 10'h2AA);
    check("t2_pkt_e", cap[5], 10'h0F0);
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t2_idle_after", busy, 1'b0);
    repeat (4) @(negedge clk);
    check("t2_fifth_dropped", cap.size(), 6);

    // No ack after sync: timeout, recover, then the next packet goes out
    ack_en = 1'b0;
    push_pkt(10'h0AA);
    push_pkt(10'h355);
    n = 0;
    while (tx !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t3_sync_low", tx, 1'b0);
    n = 0;
    while (tx !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t3_sync_high", tx, 1'b1);
    n = 0;
    while (err !== 1'b1 && n < T + 50) begin
      @(negedge clk);
      n++;
    end
    check("t3_timeout_cycles", n, T);
    ack_en = 1'b1;
    n = 0;
    while (tx !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) check("t3_err_one_cycle", err, 1'b0);
    end
    check("t3_err_to_next_sync", n, 9);
    wait_done("t3_done", 400);
    check("t3_second_pkt", cap[cap.size() - 1], 10'h355);
    repeat (4) @(negedge clk);

    // Reset during data bit 5 with another packet queued
    push_pkt(10'h3C3);
    push_pkt(10'h0FF);
    n = 0;
    while (cur_bit != 5 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t4_reached_bit5", cur_bit, 5);
    check("t4_bit5_low", tx, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("t4_rst_tx", tx, 1'b1);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_empty", empty, 1'b1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (200) @(negedge clk);
    check("t4_still_idle", {busy, empty}, 2'b01);

    // One-cycle rx glitch while idle and empty
    glitch_req++;
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("t5_glitch_ignored", bad, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
